// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the register scoreboard: issue descriptor, opcode set and
// the decode helpers that turn a raw instruction into scoreboard usage.
package regfile_scoreboard_pkg;

    localparam int unsigned NUM_REGS_DEFAULT = 32;
    localparam int unsigned REG_AW           = $clog2(NUM_REGS_DEFAULT);

    typedef logic [31:0] instruction_t;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_AMO      = 7'b0101111,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rs1_used;
        logic              rs2_used;
        logic              rd_we;
    } scoreboard_issue_t;

    function automatic logic reads_rs1(instruction_t instr);
        case (opcode_e'(instr[6:0]))
            OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_AMO,
            OPC_OP, OPC_BRANCH, OPC_JALR: return 1'b1;
            // CSR immediate forms (funct3[2] set) carry a uimm, not rs1
            OPC_SYSTEM:                   return ~instr[14];
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(instruction_t instr);
        case (opcode_e'(instr[6:0]))
            OPC_STORE, OPC_AMO, OPC_OP, OPC_BRANCH: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(instruction_t instr);
        case (opcode_e'(instr[6:0]))
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_AMO, OPC_OP,
            OPC_LUI, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic scoreboard_issue_t to_issue(instruction_t instr);
        scoreboard_issue_t s;
        s.rs1      = instr[19:15];
        s.rs2      = instr[24:20];
        s.rd       = instr[11:7];
        s.rs1_used = reads_rs1(instr);
        s.rs2_used = reads_rs2(instr);
        s.rd_we    = writes_rd(instr);
        return s;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue, retire, flush and status signals between decode/writeback and the
// register scoreboard.
interface regfile_scoreboard_if #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned NUM_RETIRE   = 2,
    parameter int unsigned MAX_INFLIGHT = 4
);
    localparam int unsigned RAW = $clog2(NUM_REGS);
    localparam int unsigned TW  = $clog2(MAX_INFLIGHT + 1);

    logic                      issue_valid_i;
    logic                      issue_ready_o;
    logic [RAW-1:0]            issue_rs1_i;
    logic [RAW-1:0]            issue_rs2_i;
    logic                      issue_rs1_used_i;
    logic                      issue_rs2_used_i;
    logic [RAW-1:0]            issue_rd_i;
    logic                      issue_rd_we_i;
    logic [NUM_RETIRE-1:0]     retire_valid_i;
    logic [NUM_RETIRE*RAW-1:0] retire_rd_i;
    logic                      flush_i;
    logic [TW-1:0]             inflight_o;
    logic                      busy_o;
    logic                      err_o;

    modport master (
        output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rs1_used_i,
               issue_rs2_used_i, issue_rd_i, issue_rd_we_i,
               retire_valid_i, retire_rd_i, flush_i,
        input  issue_ready_o, inflight_o, busy_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rs1_used_i,
               issue_rs2_used_i, issue_rd_i, issue_rd_we_i,
               retire_valid_i, retire_rd_i, flush_i,
        output issue_ready_o, inflight_o, busy_o, err_o
    );
endinterface

// File: rtl/scoreboard_counter.sv
// Saturating up/down counter: +1 on inc, -dec per cycle, clamped at zero with
// an underflow flag; clr wins over both.
module scoreboard_counter #(
    parameter int unsigned W  = 2,
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [DW-1:0] dec,
    output logic [W-1:0]  q,
    output logic          nz,
    output logic          underflow
);
    localparam int unsigned SW = ((W > DW) ? W : DW) + 1;
    localparam logic [SW-1:0] MAXV = {{(SW-W){1'b0}}, {W{1'b1}}};

    logic [SW-1:0] up;
    logic [SW-1:0] dn;
    logic [SW-1:0] nxt;

    // inc and dec are netted first, so a same-cycle +1/-1 on zero is not an underflow
    always_comb begin
        up        = SW'(q) + SW'(inc);
        dn        = SW'(dec);
        underflow = up < dn;
        nxt       = underflow ? '0 : up - dn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (nxt > MAXV) begin
            q <= '1;
        end else begin
            q <= nxt[W-1:0];
        end
    end

    assign nz = |q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard between ID and EX.
// Build option: SCOREBOARD_BYPASS_EN lets same-cycle retires release hazards.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS     = NUM_REGS_DEFAULT,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned NUM_RETIRE   = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    regfile_scoreboard_if.slave  sb
);
    localparam int unsigned RAW = $clog2(NUM_REGS);
    localparam int unsigned RDW = $clog2(NUM_RETIRE + 1);
    localparam int unsigned TW  = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] pend     [NUM_REGS];
    logic             pend_nzq [NUM_REGS];
    logic             uf       [NUM_REGS];
    logic [RDW-1:0]   ret_cnt  [NUM_REGS];
    logic [RAW-1:0]   ret_rd   [NUM_RETIRE];
    logic             pend_nz  [NUM_REGS];
    logic             pend_sat [NUM_REGS];
    logic [RDW-1:0]   ret_total;
    logic [TW-1:0]    total;
    logic             total_full;
    logic             busy;
    logic             uf_total;
    logic             any_uf;
    logic             err;
    logic             src_haz;
    logic             full;
    logic             ready;
    logic             inc_en;

    assign pend[0]     = '0;
    assign pend_nzq[0] = 1'b0;
    assign uf[0]       = 1'b0;

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) ret_cnt[r] = '0;
        ret_total = '0;
        for (int unsigned c = 0; c < NUM_RETIRE; c++) begin
            ret_rd[c] = sb.retire_rd_i[c*RAW +: RAW];
            if (sb.retire_valid_i[c] && ret_rd[c] != '0) begin
                ret_cnt[ret_rd[c]] = ret_cnt[ret_rd[c]] + RDW'(1);
                ret_total          = ret_total + RDW'(1);
            end
        end
    end

`ifdef SCOREBOARD_BYPASS_EN
    localparam int unsigned EW = (CNT_W > RDW) ? CNT_W : RDW;
    // pend_eff != 0 iff pend exceeds this cycle's retires; pend_eff is max only with no retire
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pend_nz[r]  = pend_nzq[r] && (EW'(pend[r]) > EW'(ret_cnt[r]));
            pend_sat[r] = (&pend[r]) && (ret_cnt[r] == '0);
        end
        total_full = (total == TW'(MAX_INFLIGHT)) && (ret_total == '0);
    end
`else
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pend_nz[r]  = pend_nzq[r];
            pend_sat[r] = &pend[r];
        end
        total_full = (total == TW'(MAX_INFLIGHT));
    end
`endif

    always_comb begin
        src_haz = (sb.issue_rs1_used_i && pend_nz[sb.issue_rs1_i]) ||
                  (sb.issue_rs2_used_i && pend_nz[sb.issue_rs2_i]);
        full    = total_full ||
                  (sb.issue_rd_we_i && sb.issue_rd_i != '0 && pend_sat[sb.issue_rd_i]);
        ready   = !src_haz && !full && !sb.flush_i;
        inc_en  = sb.issue_valid_i && ready && sb.issue_rd_we_i && sb.issue_rd_i != '0;
        any_uf  = uf_total;
        for (int unsigned r = 0; r < NUM_REGS; r++) any_uf = any_uf | uf[r];
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
        scoreboard_counter #(.W(CNT_W), .DW(RDW)) u_cnt (
            .clk       (clk_i),
            .rst_n     (reset_ni),
            .clr       (sb.flush_i),
            .inc       (inc_en && (sb.issue_rd_i == RAW'(r))),
            .dec       (ret_cnt[r]),
            .q         (pend[r]),
            .nz        (pend_nzq[r]),
            .underflow (uf[r])
        );
    end

    scoreboard_counter #(.W(TW), .DW(RDW)) u_total (
        .clk       (clk_i),
        .rst_n     (reset_ni),
        .clr       (sb.flush_i),
        .inc       (inc_en),
        .dec       (ret_total),
        .q         (total),
        .nz        (busy),
        .underflow (uf_total)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err <= 1'b0;
        end else if (!sb.flush_i && any_uf) begin
            err <= 1'b1;
        end
    end

    assign sb.issue_ready_o = ready;
    assign sb.inflight_o    = total;
    assign sb.busy_o        = busy;
    assign sb.err_o         = err;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed checks of regfile_scoreboard against a per-register
// pending-count model; honours SCOREBOARD_BYPASS_EN.
module tb_regfile_scoreboard;
    localparam int NR  = 32;
    localparam int CW  = 2;
    localparam int MI  = 4;
    localparam int NRT = 2;
    localparam int AW  = 5;
    localparam int PMAX = (1 << CW) - 1;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_ni;

    regfile_scoreboard_if #(.NUM_REGS(NR), .NUM_RETIRE(NRT), .MAX_INFLIGHT(MI)) sb ();

    regfile_scoreboard #(
        .NUM_REGS(NR), .CNT_W(CW), .MAX_INFLIGHT(MI), .NUM_RETIRE(NRT)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .sb       (sb.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pend_m [NR];
    int total_m;
    bit err_m;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_issue(input bit v, input int rs1, input bit u1,
                             input int rs2, input bit u2, input int rd, input bit we);
        sb.issue_valid_i    = v;
        sb.issue_rs1_i      = AW'(rs1);
        sb.issue_rs1_used_i = u1;
        sb.issue_rs2_i      = AW'(rs2);
        sb.issue_rs2_used_i = u2;
        sb.issue_rd_i       = AW'(rd);
        sb.issue_rd_we_i    = we;
    endtask

    task automatic set_ret(input bit v0, input int r0, input bit v1, input int r1);
        sb.retire_valid_i = {v1, v0};
        sb.retire_rd_i    = {AW'(r1), AW'(r0)};
    endtask

    task automatic idle();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_ret(0, 0, 0, 0);
        sb.flush_i = 1'b0;
    endtask

    task automatic model_clear();
        foreach (pend_m[r]) pend_m[r] = 0;
        total_m = 0;
    endtask

    function automatic int ret_of(input int r);
        int n = 0;
        for (int c = 0; c < NRT; c++)
            if (sb.retire_valid_i[c] && int'(sb.retire_rd_i[c*AW +: AW]) == r && r != 0) n++;
        return n;
    endfunction

    function automatic int eff(input int r);
        int v;
        if (r == 0) return 0;
        v = pend_m[r];
        if (BYP) v = v - ret_of(r);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit model_ready();
        int tot = total_m;
        bit haz, full;
        if (BYP) begin
            for (int r = 1; r < NR; r++) tot = tot - ret_of(r);
            if (tot < 0) tot = 0;
        end
        haz  = (sb.issue_rs1_used_i && eff(int'(sb.issue_rs1_i)) != 0) ||
               (sb.issue_rs2_used_i && eff(int'(sb.issue_rs2_i)) != 0);
        full = (tot == MI) ||
               (sb.issue_rd_we_i && sb.issue_rd_i != 0 && eff(int'(sb.issue_rd_i)) == PMAX);
        return !haz && !full && !sb.flush_i;
    endfunction

    task automatic model_update(input bit rdy);
        int inc_rd, all, v;
        if (sb.flush_i) begin
            model_clear();
            return;
        end
        inc_rd = (sb.issue_valid_i && rdy && sb.issue_rd_we_i && sb.issue_rd_i != 0)
                 ? int'(sb.issue_rd_i) : 0;
        all = 0;
        for (int r = 1; r < NR; r++) begin
            all += ret_of(r);
            v = pend_m[r] + ((inc_rd == r) ? 1 : 0) - ret_of(r);
            if (v < 0) begin err_m = 1'b1; v = 0; end
            if (v > PMAX) v = PMAX;
            pend_m[r] = v;
        end
        v = total_m + ((inc_rd != 0) ? 1 : 0) - all;
        if (v < 0) begin err_m = 1'b1; v = 0; end
        total_m = v;
    endtask

    // Inputs are driven at the falling edge; outputs are compared 1 time unit later.
    task automatic step();
        bit rdy;
        #1;
        rdy = model_ready();
        chk("ready", int'(sb.issue_ready_o), int'(rdy));
        chk("inflight", int'(sb.inflight_o), total_m);
        chk("busy", int'(sb.busy_o), int'(total_m != 0));
        chk("err", int'(sb.err_o), int'(err_m));
        @(posedge clk);
        model_update(rdy);
        @(negedge clk);
    endtask

    task automatic drain();
        int a, b, guard;
        guard = 0;
        while (total_m > 0 && guard < 40) begin
            idle();
            a = -1; b = -1;
            for (int r = 1; r < NR; r++) if (a < 0 && pend_m[r] > 0) a = r;
            for (int r = 1; r < NR; r++)
                if (b < 0 && pend_m[r] - ((r == a) ? 1 : 0) > 0) b = r;
            if (a < 0) break;
            set_ret(1, a, b >= 0, (b >= 0) ? b : 0);
            step();
            guard++;
        end
        idle();
        #1;
        chk("drain_inflight", int'(sb.inflight_o), 0);
        step();
    endtask

    task automatic pulse_reset(input string tag);
        reset_ni = 1'b0;
        #1;
        chk({tag, "_rst_inflight"}, int'(sb.inflight_o), 0);
        chk({tag, "_rst_busy"}, int'(sb.busy_o), 0);
        chk({tag, "_rst_err"}, int'(sb.err_o), 0);
        model_clear();
        err_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
    endtask

    task automatic random_cycle();
        int avail [NR];
        int cand [$];
        bit v [2];
        int r [2];
        foreach (pend_m[i]) avail[i] = pend_m[i];
        set_issue($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0);
        for (int c = 0; c < 2; c++) begin
            cand.delete();
            for (int i = 1; i < NR; i++) if (avail[i] > 0) cand.push_back(i);
            v[c] = $urandom_range(0, 9) < 6;
            if ($urandom_range(0, 49) == 0 || cand.size() == 0) begin
                r[c] = $urandom_range(0, 7);
            end else begin
                r[c] = cand[$urandom_range(0, cand.size() - 1)];
            end
            if (v[c] && r[c] != 0 && avail[r[c]] > 0) avail[r[c]]--;
        end
        set_ret(v[0], r[0], v[1], r[1]);
        sb.flush_i = ($urandom_range(0, 49) == 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni = 1'b0;
        idle();
        model_clear();
        err_m = 1'b0;
        #2;
        chk("reset_ready", int'(sb.issue_ready_o), 1);
        chk("reset_inflight", int'(sb.inflight_o), 0);
        chk("reset_busy", int'(sb.busy_o), 0);
        chk("reset_err", int'(sb.err_o), 0);
        @(negedge clk);
        reset_ni = 1'b1;

        // producer x5, dependent reader, release timing
        idle(); set_issue(1, 0, 0, 0, 0, 5, 1);
        #1; chk("t1_issue_ready", int'(sb.issue_ready_o), 1);
        step();
        idle(); set_issue(1, 5, 1, 0, 0, 6, 0);
        #1; chk("t1_inflight", int'(sb.inflight_o), 1);
        chk("t1_stall", int'(sb.issue_ready_o), 0);
        step();
        set_ret(1, 5, 0, 0);
        #1; chk("t1_release_same", int'(sb.issue_ready_o), int'(BYP));
        step();
        set_ret(0, 0, 0, 0);
        #1; chk("t1_release_next", int'(sb.issue_ready_o), 1);
        chk("t1_inflight_zero", int'(sb.inflight_o), 0);
        step();

        // x0 is never tracked
        idle(); set_issue(1, 0, 0, 0, 0, 0, 1);
        step();
        idle(); set_issue(1, 0, 1, 0, 1, 3, 0);
        #1; chk("t2_inflight", int'(sb.inflight_o), 0);
        chk("t2_x0_reader", int'(sb.issue_ready_o), 1);
        step();

        // capacity limit
        for (int i = 1; i <= 4; i++) begin
            idle(); set_issue(1, 0, 0, 0, 0, i, 1);
            step();
        end
        idle(); set_issue(1, 0, 0, 0, 0, 10, 1);
        #1; chk("t3_inflight", int'(sb.inflight_o), 4);
        chk("t3_full", int'(sb.issue_ready_o), 0);
        step();
        set_ret(1, 2, 0, 0);
        #1; chk("t3_retire_same", int'(sb.issue_ready_o), int'(BYP));
        step();
        if (!BYP) begin
            set_ret(0, 0, 0, 0);
            #1; chk("t3_retire_next", int'(sb.issue_ready_o), 1);
            step();
        end
        drain();

        // per-register saturation and dual retire
        for (int i = 0; i < 3; i++) begin
            idle(); set_issue(1, 0, 0, 0, 0, 7, 1);
            step();
        end
        idle(); set_issue(1, 0, 0, 0, 0, 7, 1);
        #1; chk("t4_sat_block", int'(sb.issue_ready_o), 0);
        chk("t4_inflight3", int'(sb.inflight_o), 3);
        step();
        idle(); set_ret(1, 7, 1, 7);
        step();
        idle(); set_issue(1, 7, 1, 0, 0, 0, 0);
        #1; chk("t4_inflight1", int'(sb.inflight_o), 1);
        chk("t4_still_pending", int'(sb.issue_ready_o), 0);
        step();
        drain();

        // underflow is sticky through flush
        idle(); set_ret(1, 9, 0, 0);
        step();
        idle();
        #1; chk("t5_err_set", int'(sb.err_o), 1);
        sb.flush_i = 1'b1;
        step();
        idle();
        #1; chk("t5_err_after_flush", int'(sb.err_o), 1);
        step();

        // flush with simultaneous issue
        for (int i = 1; i <= 3; i++) begin
            idle(); set_issue(1, 0, 0, 0, 0, i, 1);
            step();
        end
        idle(); set_issue(1, 0, 0, 0, 0, 4, 1); sb.flush_i = 1'b1;
        #1; chk("t6_inflight3", int'(sb.inflight_o), 3);
        chk("t6_flush_block", int'(sb.issue_ready_o), 0);
        step();
        idle();
        #1; chk("t6_inflight0", int'(sb.inflight_o), 0);
        chk("t6_busy0", int'(sb.busy_o), 0);
        step();

        // asynchronous reset mid-operation with state pending
        for (int i = 11; i <= 12; i++) begin
            idle(); set_issue(1, 0, 0, 0, 0, i, 1);
            step();
        end
        idle();
        #2;
        pulse_reset("t7");

        for (int n = 0; n < 1500; n++) begin
            random_cycle();
            if (n == 700) begin
                idle();
                #2;
                pulse_reset("rnd");
            end
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register scoreboard replacing the single-pair RAW check in the decode stage. Tracks every in-flight register write with a per-register pending counter, so multi-cycle and out-of-stage-order writers (loads, CSR ops, future multiplier) are covered. Sits between ID and EX:
- decode presents each instruction's source/destination usage at the issue port;
- the block stalls issue while any source is pending, or while capacity is exhausted;
- writeback channels retire pending writes.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; x0 is never tracked.
- CNT_W, 2: width of each per-register pending counter.
- MAX_INFLIGHT, 4: maximum total outstanding writes across all registers.
- NUM_RETIRE, 2: number of independent retire channels.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- issue_valid_i  in  1  decode offers an instruction.
- issue_ready_o  out  1  instruction may issue this cycle.
- issue_rs1_i / issue_rs2_i  in  $clog2(NUM_REGS) each  source registers.
- issue_rs1_used_i / issue_rs2_used_i  in  1 each  source is actually read; driven from the rs1/rs2-read decode helpers.
- issue_rd_i  in  $clog2(NUM_REGS)  destination register.
- issue_rd_we_i  in  1  instruction writes the register file.
- retire_valid_i  in  NUM_RETIRE  per-channel retire strobe.
- retire_rd_i  in  NUM_RETIRE*$clog2(NUM_REGS)  per-channel retired destination.
- flush_i  in  1  squash all in-flight writers.
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  current total outstanding writes.
- busy_o  out  1  inflight_o != 0.
- err_o  out  1  sticky protocol error.

## Operation
- State:
  - pend[r], CNT_W bits, one per register r in 1..NUM_REGS-1; pend[0] is constant 0.
  - total, the inflight counter.
  - err, the sticky error flag.
- Hazard: src_haz = (rs1_used && pend_eff[rs1] != 0) || (rs2_used && pend_eff[rs2] != 0).
- Full: full = total_eff == MAX_INFLIGHT, or (rd_we && rd != 0 && pend_eff[rd] == 2^CNT_W-1).
- issue_ready_o = !src_haz && !full && !flush_i. This is combinational from the current inputs and state.
- Issue fire = issue_valid_i && issue_ready_o. On fire with rd_we && rd != 0: pend[rd] +1 and total +1.
- Issue with rd == 0, or with rd_we low, changes no state.
- Retire: each valid channel does pend[rd] −1 and total −1.
  - Retires are summed per register, so two channels retiring the same rd decrement it by 2.
  - A retire to x0 is ignored.
- The same-cycle issue and retire deltas on the same register are summed before update.
- Underflow: a retire to a register whose pend is 0 (after same-cycle retires are summed) sets err and leaves that counter at 0.
- flush_i: all pend ← 0 and total ← 0 next cycle. Issue and retire in the same cycle are ignored; err is held.
- err clears only on reset.

## Timing
- Reset, asynchronous on reset_ni low: all pend = 0, total = 0, err = 0.
  - Outputs during reset: issue_ready_o = 1 when the issue inputs are hazard-free (always true with all counters zero); inflight_o = 0; busy_o = 0; err_o = 0.
  - Reset asserted mid-operation discards all counts immediately, without waiting for a clock edge.
- Issue to visible hazard: one cycle. An instruction issued at edge N makes pend[rd] nonzero from cycle N+1.
- Retire to release, without bypass: one cycle. The consumer's issue_ready_o rises in the cycle after the retire strobe.
- Counters never wrap. Overflow is prevented by the full condition; underflow is clamped and flagged.
- inflight_o, busy_o and err_o are registered and change only on a clock edge or on reset.

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - pend_eff and total_eff subtract the same-cycle retires.
  - A consumer can therefore issue in the same cycle its producer retires; this requires writeback-to-decode forwarding in the datapath.
- SCOREBOARD_BYPASS_EN undefined:
  - pend_eff = pend and total_eff = total.
  - Minimum producer-to-consumer release is one cycle after the retire.

## Structure
- Package additions:
  - scoreboard_issue_t, a struct of rs1, rs2, rd, rs1_used, rs2_used, rd_we;
  - the NUM_REGS default constant;
  - a helper mapping instruction_t to scoreboard_issue_t, built from the existing rs1/rs2-read and regfile-write helpers.
- One sub-module, scoreboard_counter: a single saturating up/down counter with an inc input, a multi-bit dec count, clr, an underflow flag and a nonzero flag. It is instantiated NUM_REGS−1 times plus once for total.

## Test plan
- Reset, then issue with rd=5 and rd_we=1 -> inflight_o=1 next cycle. A following issue with rs1_used=1, rs1=5 sees issue_ready_o=0 until retire_rd=5 is strobed. Release is the same cycle with bypass, the next cycle without.
- Issue rd=0 with rd_we=1 -> inflight_o stays 0, and a later reader of x0 never stalls.
- Four issues to rd=1,2,3,4 with MAX_INFLIGHT=4 -> issue_ready_o=0 for a hazard-free fifth instruction. One retire (rd=2) -> ready again.
- Issue rd=7 three times with CNT_W=2 -> the fourth write to rd=7 is blocked (counter at 3). Two channels retiring rd=7 in the same cycle -> pend[7]=1 and inflight_o=1.
- Retire rd=9 with pend[9]=0 -> err_o=1 next cycle and stays 1 through a flush; it clears only when reset_ni is pulsed low.
- flush_i with inflight_o=3 and a simultaneous issue -> inflight_o=0 next cycle, the issue does not fire, busy_o=0. Asserting reset_ni low mid-cycle -> outputs zero immediately.
